// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave-side FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lane;
      HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_byte_ram.sv
// DEPTH x 32 storage: byte-enabled synchronous write, asynchronous read.
module ahb_byte_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Hclk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge Hclk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_responder.sv
// AHB-Lite slave endpoint: windowed byte-writable memory with wait states and two-cycle ERROR.
// state   | meaning
// IDLE    | ready, OKAY; may accept an address phase (completing cycle at zero wait)
// WAIT    | Hreadyout low, counting down inserted wait states
// ERR1    | first ERROR cycle, Hreadyout low
// ERR2    | second ERROR cycle, Hreadyout high; may accept like IDLE
module ahb_slave_responder
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hburst,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [2:0] WS        = 3'(WAIT_STATES);
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);

  slave_state_e  state;
  logic [2:0]    wait_cnt;
  logic          dp_valid, dp_write;
  logic [2:0]    dp_size;
  logic [AW-1:0] dp_word;
  logic [1:0]    dp_lane;

  logic [31:0]   offset;
  logic          accept, illegal, commit, load_rd;
  logic [3:0]    wr_be;
  logic [31:0]   wr_lanes, ram_rdata, merged, shifted, rd_data;
  logic [AW-1:0] rd_word;
  logic [1:0]    rd_lane;
  logic [2:0]    rd_size;
  logic          unused_ok;

  assign offset  = Haddr - BASE_ADDR;
  assign accept  = Hreadyin & Hreadyout & Htrans[1];
  assign illegal = (offset >= 32'(4*DEPTH)) || (Hsize > HSIZE_WORD)
                || (Hsize == HSIZE_HALF && Haddr[0])
                || (Hsize == HSIZE_WORD && Haddr[1:0] != 2'b00);

  assign commit   = Hreadyout & dp_valid & dp_write;
  assign wr_be    = byte_enables(dp_size, dp_lane);
  assign wr_lanes = (dp_size == HSIZE_BYTE) ? {4{Hwdata[7:0]}} :
                    (dp_size == HSIZE_HALF) ? {2{Hwdata[15:0]}} : Hwdata;

  // Zero-wait reads load Hrdata at the accept edge; otherwise at the edge leaving WAIT.
  assign rd_word = ZERO_WAIT ? offset[AW+1:2] : dp_word;
  assign rd_lane = ZERO_WAIT ? offset[1:0]    : dp_lane;
  assign rd_size = ZERO_WAIT ? Hsize          : dp_size;
  assign load_rd = ZERO_WAIT ? (accept & ~illegal & ~Hwrite)
                             : (state == ST_WAIT && wait_cnt == 3'd1 && !dp_write);

  ahb_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .Hclk  (Hclk),
    .we    (commit),
    .be    (wr_be),
    .waddr (dp_word),
    .wdata (wr_lanes),
    .raddr (rd_word),
    .rdata (ram_rdata)
  );

  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (commit && wr_be[i] && dp_word == rd_word) merged[8*i +: 8] = wr_lanes[8*i +: 8];
    end
  end

  assign shifted = merged >> {rd_lane, 3'b000};
  assign rd_data = (rd_size == HSIZE_BYTE) ? {24'd0, shifted[7:0]} :
                   (rd_size == HSIZE_HALF) ? {16'd0, shifted[15:0]} : shifted;

  assign unused_ok = ^{Hburst, Htrans[0]};

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      wait_cnt  <= 3'd0;
      Hreadyout <= 1'b1;
      Hresp     <= HRESP_OKAY;
      Hrdata    <= 32'd0;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_size   <= 3'd0;
      dp_word   <= '0;
      dp_lane   <= 2'd0;
    end else begin
      if (load_rd) Hrdata <= rd_data;
      case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state     <= ST_IDLE;
            Hreadyout <= 1'b1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          Hreadyout <= 1'b1;
        end
        default: begin
          if (accept && illegal) begin
            state     <= ST_ERR1;
            Hreadyout <= 1'b0;
            Hresp     <= HRESP_ERROR;
            dp_valid  <= 1'b0;
          end else if (accept) begin
            dp_valid <= 1'b1;
            dp_write <= Hwrite;
            dp_size  <= Hsize;
            dp_word  <= offset[AW+1:2];
            dp_lane  <= offset[1:0];
            Hresp    <= HRESP_OKAY;
            if (ZERO_WAIT) begin
              state     <= ST_IDLE;
              Hreadyout <= 1'b1;
            end else begin
              state     <= ST_WAIT;
              wait_cnt  <= WS;
              Hreadyout <= 1'b0;
            end
          end else begin
            state     <= ST_IDLE;
            Hreadyout <= 1'b1;
            Hresp     <= HRESP_OKAY;
            dp_valid  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Directed bench: zero-wait, two-wait and three-wait responders on one shared bus.
module tb_ahb_slave_responder;

  logic        Hclk = 1'b0;
  logic        Hresetn, rst3_n, rdy_en;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize, Hburst;
  logic [31:0] Haddr, Hwdata;
  logic        ro0, ro2, ro3;
  logic [1:0]  rs0, rs2, rs3;
  logic [31:0] rd0, rd2, rd3;
  int checks = 0;
  int failures = 0;

  always #5 Hclk = ~Hclk;

  ahb_slave_responder #(.WAIT_STATES(0)) dut0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreadyin(ro0 & rdy_en), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(ro0), .Hresp(rs0), .Hrdata(rd0));

  ahb_slave_responder #(.WAIT_STATES(2)) dut2 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreadyin(ro2), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(ro2), .Hresp(rs2), .Hrdata(rd2));

  ahb_slave_responder #(.WAIT_STATES(3)) dut3 (
    .Hclk(Hclk), .Hresetn(Hresetn & rst3_n), .Hreadyin(ro3), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(ro3), .Hresp(rs3), .Hrdata(rd3));

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic ap(input logic [1:0] tr, input logic wr, input logic [2:0] sz, input logic [31:0] a);
    Htrans = tr;
    Hwrite = wr;
    Hsize  = sz;
    Haddr  = a;
  endtask

  task automatic idle();
    Htrans = 2'b00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Hresetn = 1'b0; rst3_n = 1'b1; rdy_en = 1'b1;
    Htrans = 2'b00; Hwrite = 1'b0; Hsize = 3'd2; Hburst = 3'd0;
    Haddr = 32'h0; Hwdata = 32'h0;
    repeat (3) tick();
    check("rst_ready", 32'(ro0), 32'd1);
    check("rst_resp",  32'(rs0), 32'd0);
    check("rst_rdata", rd0, 32'h0);
    Hresetn = 1'b1;
    tick();

    // word write then word read
    ap(2'b10, 1'b1, 3'd2, 32'h8000_0000); tick();
    Hwdata = 32'hDEADBEEF; idle();
    check("ww_ready", 32'(ro0), 32'd1);
    tick();
    ap(2'b10, 1'b0, 3'd2, 32'h8000_0000); tick();
    check("wr_rdata", rd0, 32'hDEADBEEF);
    check("wr_ready", 32'(ro0), 32'd1);
    idle(); tick();

    // byte writes NONSEQ/SEQ, merged word read, byte read
    ap(2'b10, 1'b1, 3'd0, 32'h8000_0000); tick();
    Hwdata = 32'h24; ap(2'b11, 1'b1, 3'd0, 32'h8000_0001); tick();
    Hwdata = 32'hA1; ap(2'b11, 1'b1, 3'd0, 32'h8000_0002); tick();
    Hwdata = 32'hB2; ap(2'b11, 1'b1, 3'd0, 32'h8000_0003); tick();
    check("bw_ready", 32'(ro0), 32'd1);
    Hwdata = 32'hC3; ap(2'b10, 1'b0, 3'd2, 32'h8000_0000); tick();
    check("bw_word", rd0, 32'hC3B2A124);
    ap(2'b10, 1'b0, 3'd0, 32'h8000_0002); tick();
    check("br_byte", rd0, 32'h0000_00B2);
    idle(); tick();

    // halfword write into upper lanes with forwarding, halfword read
    ap(2'b10, 1'b1, 3'd2, 32'h8000_0004); tick();
    Hwdata = 32'hAABBCCDD; ap(2'b10, 1'b1, 3'd1, 32'h8000_0006); tick();
    Hwdata = 32'h0000_5566; ap(2'b10, 1'b0, 3'd2, 32'h8000_0004); tick();
    check("hw_word", rd0, 32'h5566CCDD);
    ap(2'b10, 1'b0, 3'd1, 32'h8000_0004); tick();
    check("hr_half", rd0, 32'h0000_CCDD);
    idle(); tick();

    // write immediately followed by read of the same word
    ap(2'b10, 1'b1, 3'd2, 32'h8000_0008); tick();
    Hwdata = 32'h11223344; ap(2'b10, 1'b0, 3'd2, 32'h8000_0008); tick();
    check("fwd_rdata", rd0, 32'h11223344);
    idle(); tick();

    // Hreadyin low: address phase must be ignored
    rdy_en = 1'b0; ap(2'b10, 1'b1, 3'd2, 32'h8000_0000); tick();
    rdy_en = 1'b1; idle(); Hwdata = 32'hFFFF_FFFF;
    check("nordy_resp", 32'(rs0), 32'd0);
    tick();
    ap(2'b10, 1'b0, 3'd2, 32'h8000_0000); tick();
    check("nordy_mem", rd0, 32'hC3B2A124);
    idle(); tick();

    // out-of-window write, then unaligned halfword accepted in ERR2
    ap(2'b10, 1'b1, 3'd2, 32'h8000_0400); tick();
    check("oow_e1_ready", 32'(ro0), 32'd0);
    check("oow_e1_resp",  32'(rs0), 32'd1);
    Hwdata = 32'hFFFF_FFFF; idle(); tick();
    check("oow_e2_ready", 32'(ro0), 32'd1);
    check("oow_e2_resp",  32'(rs0), 32'd1);
    ap(2'b10, 1'b0, 3'd1, 32'h8000_0001); tick();
    check("una_e1_ready", 32'(ro0), 32'd0);
    check("una_e1_resp",  32'(rs0), 32'd1);
    idle(); tick();
    check("una_e2_ready", 32'(ro0), 32'd1);
    check("una_e2_resp",  32'(rs0), 32'd1);
    check("err_rdata_hold", rd0, 32'hC3B2A124);
    ap(2'b10, 1'b0, 3'd2, 32'h8000_0000); tick();
    check("err2_acc_resp", 32'(rs0), 32'd0);
    check("err2_acc_mem",  rd0, 32'hC3B2A124);
    // illegal size and below-window address
    ap(2'b10, 1'b0, 3'd3, 32'h8000_0000); tick();
    check("sz3_resp", 32'(rs0), 32'd1);
    idle(); tick();
    ap(2'b10, 1'b0, 3'd2, 32'h7FFF_FFFC); tick();
    check("below_resp",  32'(rs0), 32'd1);
    check("below_ready", 32'(ro0), 32'd0);
    idle(); tick(); tick();
    check("err_done_resp", 32'(rs0), 32'd0);
    check("err_done_ready", 32'(ro0), 32'd1);
    repeat (6) tick();

    // two wait states
    ap(2'b10, 1'b1, 3'd2, 32'h8000_0004); tick();
    idle(); Hwdata = 32'h0BADF00D;
    check("w2_wr_c1", 32'(ro2), 32'd0); tick();
    check("w2_wr_c2", 32'(ro2), 32'd0); tick();
    check("w2_wr_c3", 32'(ro2), 32'd1);
    tick();
    ap(2'b10, 1'b0, 3'd2, 32'h8000_0004); tick();
    idle();
    check("w2_rd_c1", 32'(ro2), 32'd0); tick();
    check("w2_rd_c2", 32'(ro2), 32'd0); tick();
    check("w2_rd_ready", 32'(ro2), 32'd1);
    check("w2_rd_resp",  32'(rs2), 32'd0);
    check("w2_rd_data",  rd2, 32'h0BADF00D);
    repeat (8) tick();

    // three wait states, then reset in the middle of WAIT
    ap(2'b10, 1'b1, 3'd2, 32'h8000_0000); tick();
    idle(); Hwdata = 32'h12345678;
    tick(); tick(); tick();
    check("w3_wr_c4", 32'(ro3), 32'd1);
    tick();
    ap(2'b10, 1'b0, 3'd2, 32'h8000_0000); tick();
    idle(); tick(); tick(); tick();
    check("w3_rd_data", rd3, 32'h12345678);
    tick();
    ap(2'b10, 1'b1, 3'd2, 32'h8000_0000); tick();
    idle(); Hwdata = 32'hFFFF_FFFF; tick();
    check("w3_mid_wait", 32'(ro3), 32'd0);
    #2 rst3_n = 1'b0;
    #1;
    check("rst3_ready", 32'(ro3), 32'd1);
    check("rst3_resp",  32'(rs3), 32'd0);
    check("rst3_rdata", rd3, 32'h0);
    tick(); tick();
    rst3_n = 1'b1;
    tick();
    ap(2'b10, 1'b0, 3'd2, 32'h8000_0000); tick();
    idle(); tick(); tick(); tick();
    check("rst3_no_write", rd3, 32'h12345678);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_slave_responder.md
Name: ahb_slave_responder

Overview:
- AHB-Lite slave endpoint: the responder side for the team's AHB master driver.
- Decodes the address window at BASE_ADDR and backs it with a DEPTH-word, byte-writable 32-bit memory.
- Inserts programmable wait states and issues two-cycle ERROR responses.
- Used as the bus target in master-side bring-up benches and as the template for the bridge's AHB slave interface.

Parameters:
BASE_ADDR  32'h8000_0000  byte address of word 0; window is BASE_ADDR .. BASE_ADDR+4*DEPTH-1
DEPTH  256  memory words (power of two, 4..4096)
WAIT_STATES  0  Hreadyout-low cycles inserted in every OKAY data phase (0..7)

Ports:
Hclk  in  1  bus clock, rising edge
Hresetn  in  1  asynchronous active-low reset
Hreadyin  in  1  bus HREADY; an address phase is sampled only when 1
Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
Hwrite  in  1  1 write, 0 read
Hsize  in  3  0 byte, 1 halfword, 2 word; larger values are illegal
Hburst  in  3  accepted and ignored; every beat carries its own Haddr
Haddr  in  32  byte address
Hwdata  in  32  write data, right-justified for narrow sizes
Hreadyout  out  1  data phase completes when 1
Hresp  out  2  00 OKAY, 01 ERROR
Hrdata  out  32  read data, right-justified and zero-extended

Behaviour:
- Reset: Hresetn low asynchronously forces Hreadyout=1, Hresp=00, Hrdata=0, FSM=IDLE, wait counter=0, pending-phase registers cleared. Memory contents are not reset.
- Accept condition: Hreadyin=1 && Hreadyout=1 && Htrans[1]=1 at a rising edge. Haddr, Hwrite and Hsize are captured into the data-phase registers.
- IDLE/BUSY, or an accept edge with Hreadyin=0: nothing is captured, and the following cycle returns zero-wait OKAY.
- Error check at accept: an access is illegal if any of these holds:
  - offset = Haddr-BASE_ADDR is >= 4*DEPTH;
  - Hsize > 2;
  - the halfword is unaligned (Haddr[0]=1);
  - the word is unaligned (Haddr[1:0]!=0).
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE:
  - legal accept with WAIT_STATES=0: stay in IDLE, data phase completes next cycle;
  - legal accept with WAIT_STATES>0: go to WAIT, load counter=WAIT_STATES;
  - illegal accept: go to ERR1.
- WAIT: Hreadyout=0, Hresp=00, counter decrements each cycle. When the counter reaches 0, the next cycle is the completing cycle (Hreadyout=1), and the FSM returns to IDLE with that cycle acting as IDLE.
- ERR1: Hreadyout=0, Hresp=01; next state is ERR2.
- ERR2: Hreadyout=1, Hresp=01; memory is untouched. A new address phase may be accepted in this cycle and obeys the IDLE rules.
- Write timing:
  - memory is written at the rising edge ending the completing data-phase cycle, using the captured address and size;
  - byte: Hwdata[7:0] goes to lane offset[1:0];
  - halfword: Hwdata[15:0] goes to lanes {offset[1],0}+1..+0;
  - word: all four lanes are written, little-endian.
- Read timing:
  - Hrdata is registered, loaded at the edge entering the completing cycle, from the addressed lane(s), zero-extended;
  - Hrdata holds its value until the next read load;
  - Hrdata is not updated on writes or errors.
- Read latency:
  - WAIT_STATES=0: data valid one cycle after the accept edge;
  - otherwise: data valid 1+WAIT_STATES cycles after the accept edge.
- Write-read forwarding: a read that loads Hrdata at the same edge a write commits to an overlapping word returns the merged (new) bytes.
- Back-to-back pipelining: a write data phase completing while the next address phase is accepted is legal and required. There are no bubbles at WAIT_STATES=0.
- Reset mid-transfer abandons the transfer; no partial write may occur after Hresetn falls.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HRESP_OKAY/ERROR;
  - HSIZE_BYTE/HALF/WORD;
  - slave FSM state enum.
- Sub-module ahb_byte_ram:
  - DEPTH x 32 storage with a 4-bit byte-enable synchronous write port;
  - one asynchronous read port.
  - Forwarding and lane muxing stay in the parent.

Test Plan:
- Reset with Hresetn=0 mid-WAIT (WAIT_STATES=3) -> Hreadyout=1, Hresp=00, Hrdata=0 immediately; no memory write.
- Word write 32'hDEADBEEF @8000_0000, then word read same address, WAIT_STATES=0 -> Hrdata=32'hDEADBEEF one cycle after the read accept; Hreadyout never low.
- Byte writes 24,A1,B2,C3 @8000_0000..0003 back-to-back (NONSEQ then SEQ), then word read -> 32'hC3B2A124. Byte read @8000_0002 -> 32'h000000B2.
- Write 32'h11223344 then immediately read same word, no idle between -> Hrdata=32'h11223344 (forwarding).
- WAIT_STATES=2, read @8000_0004 -> Hreadyout low for exactly 2 cycles, then high with valid data and Hresp=00.
- Write @8000_0400 (DEPTH=256), then halfword @8000_0001 -> each gives Hreadyout 0/1 with Hresp 01 for both cycles, memory unchanged. A NONSEQ presented in ERR2 is accepted.
